tb_cmd_responder: RTL and testbench
===================================

# tb_cmd_responder

Testbench-side command responder that sits at the other end of the scenario sequencer. It samples the string arguments presented with `args_valid`, decodes and executes one command (drive a pin, wait cycles, wait for an edge, check a pin, end test), then pulses `ack` to request the next scenario line. It owns all stimulus and check pins that scenario files refer to by index, and keeps a running error count.

## Interface
- `ARGS_NB`, 5: number of string arguments per scenario line.
- `SET_WIDTH`, 16: number of drivable stimulus bits on `set_o`.
- `WAIT_WIDTH`, 16: number of observable event bits on `wait_i`.
- `CHECK_WIDTH`, 16: number of checkable bits on `check_i`.
- `clk`  in  1  testbench clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `args`  in  string[ARGS_NB]  command word in `args[0]`, operands in `args[1..]`, stable from `args_valid` until the next `ack`.
- `args_valid`  in  1  one-cycle strobe: `args` holds a new line.
- `ack`  out  1  one-cycle pulse: current command finished, next line requested.
- `set_o`  out  SET_WIDTH  stimulus bits driven by `SET`.
- `wait_i`  in  WAIT_WIDTH  event bits watched by `WTR`/`WTF`.
- `check_i`  in  CHECK_WIDTH  bits compared by `CHECK`.
- `error_cnt`  out  16  saturating count of failed checks, timeouts, bad commands.
- `test_done`  out  1  sticky, set by `END_TEST`.

## Operation
- Reset (`rst_n`=0 at an edge): `ack`=0, `set_o`=0, `error_cnt`=0, `test_done`=0, counters=0, state `S_INIT`.
- `S_INIT`: first edge with `rst_n`=1 sets `ack`, goes `S_IDLE`. This pulse starts the sequencer.
- `S_IDLE`: on `args_valid`=1, `args` are converted to integers with `$sscanf`/`atoi` and latched internally. Then decode:
  - `SET <idx> <val>`: `set_o[idx] <= val[0]`, ack.
  - `CHECK <idx> <val>`: if `check_i[idx] != val[0]`, increment `error_cnt` and `$display` the mismatch. Then ack.
  - `WAIT_CYCLES <n>`: load the 32-bit counter with n and go `S_WAIT_CYC`. If n=0, ack immediately.
  - `WTR <idx> <timeout>` / `WTF <idx> <timeout>`: go `S_WAIT_EDGE` with the polarity latched. `timeout`=0 means no timeout.
  - `END_TEST`: set `test_done`, `$display` final `error_cnt`, ack, go `S_DONE`.
  - Empty `args[0]` (blank line): NOP, ack.
  - Unknown command, or idx ≥ the relevant width: increment `error_cnt`, `$display`, ack. No pin changes.
- `S_WAIT_CYC`: decrement each cycle. At count 1, ack and go `S_IDLE`.
- `S_WAIT_EDGE`: `wait_q` is `wait_i` registered every cycle.
  - Rising edge is `wait_i[idx] & ~wait_q[idx]`; falling edge is the complement.
  - On the edge: ack, go `S_IDLE`.
  - Timeout counter expiry: increment `error_cnt`, ack, go `S_IDLE`.
  - If the edge and expiry happen in the same cycle, the edge wins and there is no error.
- `S_DONE`: terminal. Ignore `args_valid`; `ack` stays 0.
- `args_valid` outside `S_IDLE`: ignored, `error_cnt` incremented (protocol violation).
- `error_cnt` saturates at 16'hFFFF.

## Timing
- `ack` is registered and exactly one cycle wide. It is never high two cycles in a row, because the sequencer fetches on every edge where `ack`=1.
- Single-cycle commands (`SET`, `CHECK`, NOP, unknown, `END_TEST`): `ack` is high in the cycle right after the edge that samples `args_valid`. `set_o` updates at that same edge.
- `WAIT_CYCLES n` (n≥1): `ack` is high n cycles later than a `SET` would be.
- `WTR`/`WTF`: `ack` is high in the cycle after the edge where the edge condition is true. Latency is 1 cycle from the `wait_i` transition, sampled at that edge.
- Timeout t: `ack` is high t cycles after the `SET` reference point, unless the edge occurs first.
- Reset mid-command (any state): next cycle is the reset state, no `ack`, `set_o` cleared, counters and pending command discarded.

## Structure
- Package `tb_cmd_pkg`:
  - `cmd_e` enum (`CMD_NOP`, `CMD_SET`, `CMD_CHECK`, `CMD_WAIT_CYCLES`, `CMD_WTR`, `CMD_WTF`, `CMD_END`, `CMD_BAD`).
  - `state_e` enum.
  - Function `str2cmd(string)`.
  - Localparam for the `error_cnt` width (16).
- Sub-module `tb_edge_detect`: WAIT_WIDTH-bit register plus rise/fall vectors, instantiated once.

## Test plan
- Reset release → `ack` pulses exactly once in the 2nd cycle; `set_o`=0, `error_cnt`=0.
- `SET 3 1` then `CHECK 3 1` with `check_i`=`set_o` loopback → `set_o`=16'h0008, `ack` 1 cycle after each strobe, `error_cnt`=0.
- `WAIT_CYCLES 10` → `ack` exactly 10 cycles later than a `SET` would be; `WAIT_CYCLES 0` → behaves as `SET` timing.
- `WTR 2 50` with `wait_i[2]` rising at cycle 20 → `ack` at cycle 21, no error. `WTF 2 5` with no edge → `ack` at cycle 5, `error_cnt`=1.
- `FOO 1 2`, `SET 40 1`, blank line → `error_cnt` +2 with `set_o` unchanged; blank line acks with no error.
- `END_TEST` after one failed `CHECK` → `test_done`=1, `error_cnt`=1, no further `ack`. `rst_n` low during a pending `WTR` → no `ack`, then a clean `S_INIT` pulse.

Source files
------------

// File: rtl/tb_cmd_pkg.sv
// ============================================================================
// Module      : tb_cmd_pkg
// Description : Command and state encodings plus string decoder for the
//               scenario command responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tb_cmd_pkg;

    localparam int c_ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_SET,
        CMD_CHECK,
        CMD_WAIT_CYCLES,
        CMD_WTR,
        CMD_WTF,
        CMD_END,
        CMD_BAD
    } cmd_e;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_CYC,
        S_WAIT_EDGE,
        S_DONE
    } state_e;

    // A blank scenario line decodes to NOP; anything unrecognised is BAD.
    function automatic cmd_e str2cmd(input string s);
        if (s == "")                 return CMD_NOP;
        else if (s == "SET")         return CMD_SET;
        else if (s == "CHECK")       return CMD_CHECK;
        else if (s == "WAIT_CYCLES") return CMD_WAIT_CYCLES;
        else if (s == "WTR")         return CMD_WTR;
        else if (s == "WTF")         return CMD_WTF;
        else if (s == "END_TEST")    return CMD_END;
        else                         return CMD_BAD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tb_cmd_responder_edge.sv
// ============================================================================
// Module      : tb_edge_detect
// Description : Registers the watched event bits and flags per-bit rising and
//               falling transitions against the previous cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_detect #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wait_i,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_wait_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_q <= '0;
        end else begin
            r_wait_q <= wait_i;
        end
    end

    assign rise = wait_i & ~r_wait_q;
    assign fall = ~wait_i & r_wait_q;

endmodule

`default_nettype wire

// File: rtl/tb_cmd_responder.sv
// ============================================================================
// Module      : tb_cmd_responder
// Description : Decodes one scenario line per args_valid strobe, drives/checks
//               indexed pins, waits on cycles or edges, and acks for the next.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_responder
    import tb_cmd_pkg::*;
#(
    parameter int ARGS_NB     = 5,
    parameter int SET_WIDTH   = 16,
    parameter int WAIT_WIDTH  = 16,
    parameter int CHECK_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  string                  args [ARGS_NB],
    input  logic                   args_valid,
    output logic                   ack,
    output logic [SET_WIDTH-1:0]   set_o,
    input  logic [WAIT_WIDTH-1:0]  wait_i,
    input  logic [CHECK_WIDTH-1:0] check_i,
    output logic [c_ERR_CNT_W-1:0] error_cnt,
    output logic                   test_done
);

    localparam int c_SIDX_W = $clog2(SET_WIDTH);
    localparam int c_WIDX_W = $clog2(WAIT_WIDTH);
    localparam int c_CIDX_W = $clog2(CHECK_WIDTH);

    state_e                 r_state, w_state_n;
    logic                   r_ack, w_ack_n;
    logic [SET_WIDTH-1:0]   r_set, w_set_n;
    logic [c_ERR_CNT_W-1:0] r_err, w_err_n;
    logic                   r_done, w_done_n;
    logic [31:0]            r_cnt, w_cnt_n;
    logic                   r_timed, w_timed_n;
    logic                   r_pol, w_pol_n;
    logic [c_WIDX_W-1:0]    r_idx, w_idx_n;

    logic [WAIT_WIDTH-1:0]  w_rise, w_fall;
    cmd_e                   w_cmd;
    int                     w_idx;
    logic                   w_val;
    logic [31:0]            w_arg1, w_arg2;
    logic                   w_set_ok, w_chk_ok, w_wait_ok;
    logic                   w_edge;
    logic                   w_bad, w_chk_miss;
    logic [1:0]             w_err_inc;
    logic [c_ERR_CNT_W:0]   w_err_sum;

    tb_edge_detect #(
        .WIDTH (WAIT_WIDTH)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .wait_i (wait_i),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    always_comb begin
        w_cmd      = str2cmd(args[0]);
        w_idx      = args[1].atoi();
        w_val      = 1'(args[2].atoi());
        w_arg1     = 32'(args[1].atoi());
        w_arg2     = 32'(args[2].atoi());
        w_set_ok   = (w_idx >= 0) && (w_idx < SET_WIDTH);
        w_chk_ok   = (w_idx >= 0) && (w_idx < CHECK_WIDTH);
        w_wait_ok  = (w_idx >= 0) && (w_idx < WAIT_WIDTH);
        w_edge     = r_pol ? w_rise[r_idx] : w_fall[r_idx];

        w_state_n  = r_state;
        w_ack_n    = 1'b0;
        w_set_n    = r_set;
        w_done_n   = r_done;
        w_cnt_n    = r_cnt;
        w_timed_n  = r_timed;
        w_pol_n    = r_pol;
        w_idx_n    = r_idx;
        w_err_inc  = 2'd0;
        w_bad      = 1'b0;
        w_chk_miss = 1'b0;

        case (r_state)
            S_INIT: begin
                w_ack_n   = 1'b1;
                w_state_n = S_IDLE;
                if (args_valid) w_err_inc = 2'd1;
            end
            S_IDLE: begin
                if (args_valid) begin
                    w_ack_n = 1'b1;
                    case (w_cmd)
                        CMD_NOP: ;
                        CMD_SET: begin
                            if (w_set_ok) w_set_n[c_SIDX_W'(w_idx)] = w_val;
                            else          w_bad = 1'b1;
                        end
                        CMD_CHECK: begin
                            if (!w_chk_ok)
                                w_bad = 1'b1;
                            else if (check_i[c_CIDX_W'(w_idx)] != w_val)
                                w_chk_miss = 1'b1;
                        end
                        CMD_WAIT_CYCLES: begin
                            if (w_arg1 != 32'd0) begin
                                w_ack_n   = 1'b0;
                                w_cnt_n   = w_arg1;
                                w_state_n = S_WAIT_CYC;
                            end
                        end
                        CMD_WTR, CMD_WTF: begin
                            if (w_wait_ok) begin
                                w_ack_n   = 1'b0;
                                w_idx_n   = c_WIDX_W'(w_idx);
                                w_pol_n   = (w_cmd == CMD_WTR);
                                w_cnt_n   = w_arg2;
                                w_timed_n = (w_arg2 != 32'd0);
                                w_state_n = S_WAIT_EDGE;
                            end else begin
                                w_bad = 1'b1;
                            end
                        end
                        CMD_END: begin
                            w_done_n  = 1'b1;
                            w_state_n = S_DONE;
                        end
                        default: w_bad = 1'b1;
                    endcase
                    if (w_bad || w_chk_miss) w_err_inc = 2'd1;
                end
            end
            S_WAIT_CYC: begin
                if (args_valid) w_err_inc = 2'd1;
                if (r_cnt == 32'd1) begin
                    w_ack_n   = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            S_WAIT_EDGE: begin
                if (args_valid) w_err_inc = 2'd1;
                // An edge arriving on the expiry cycle is a success, not a timeout.
                if (w_edge) begin
                    w_ack_n   = 1'b1;
                    w_state_n = S_IDLE;
                end else if (r_timed && (r_cnt == 32'd1)) begin
                    w_ack_n   = 1'b1;
                    w_state_n = S_IDLE;
                    w_err_inc = w_err_inc + 2'd1;
                end else if (r_timed) begin
                    w_cnt_n = r_cnt - 32'd1;
                end
            end
            default: ;
        endcase

        w_err_sum = {1'b0, r_err} + (c_ERR_CNT_W + 1)'(w_err_inc);
        w_err_n   = w_err_sum[c_ERR_CNT_W] ? '1 : w_err_sum[c_ERR_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_ack   <= 1'b0;
            r_set   <= '0;
            r_err   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_timed <= 1'b0;
            r_pol   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ack   <= w_ack_n;
            r_set   <= w_set_n;
            r_err   <= w_err_n;
            r_done  <= w_done_n;
            r_cnt   <= w_cnt_n;
            r_timed <= w_timed_n;
            r_pol   <= w_pol_n;
            r_idx   <= w_idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_IDLE) && args_valid) begin
            if (w_bad)
                $display("tb_cmd_responder: rejected line '%s %s %s'", args[0], args[1], args[2]);
            if (w_chk_miss)
                $display("tb_cmd_responder: CHECK pin %0d is %0b, scenario wants %0b",
                         w_idx, check_i[c_CIDX_W'(w_idx)], w_val);
            if (w_cmd == CMD_END)
                $display("tb_cmd_responder: END_TEST with error_cnt=%0d", w_err_n);
        end
    end

    assign ack       = r_ack;
    assign set_o     = r_set;
    assign error_cnt = r_err;
    assign test_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_tb_cmd_responder.sv
// ============================================================================
// Module      : tb_tb_cmd_responder
// Description : Self-checking bench for tb_cmd_responder: vector table, edge
//               and reset sequences, and randomized lines against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tb_cmd_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    string       args [5];
    logic        args_valid = 1'b0;
    logic        ack;
    logic [15:0] set_o;
    logic [15:0] wait_i = '0;
    logic [15:0] check_i = '0;
    logic [15:0] error_cnt;
    logic        test_done;

    int          total = 0;
    int          bad = 0;
    logic [15:0] m_set = '0;
    int          m_err = 0;

    tb_cmd_responder #(
        .ARGS_NB     (5),
        .SET_WIDTH   (16),
        .WAIT_WIDTH  (16),
        .CHECK_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .args       (args),
        .args_valid (args_valid),
        .ack        (ack),
        .set_o      (set_o),
        .wait_i     (wait_i),
        .check_i    (check_i),
        .error_cnt  (error_cnt),
        .test_done  (test_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       c;
        string       a1;
        string       a2;
        logic [15:0] chk;
        int          lat;
        logic [15:0] set;
        int          err;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic present(input string c, input string a1, input string a2);
        args[0] = c;
        args[1] = a1;
        args[2] = a2;
        args[3] = "";
        args[4] = "";
        args_valid = 1'b1;
        step();
        args_valid = 1'b0;
    endtask

    // Lat counts edges after the sampling edge until ack is seen (SET timing = 0).
    task automatic run_cmd(input string c, input string a1, input string a2, output int lat);
        present(c, a1, a2);
        lat = 0;
        while (!ack && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic expect_cmd(input string tag, input string c, input string a1,
                              input string a2, input int exp_lat);
        int lat;
        run_cmd(c, a1, a2, lat);
        cmp({tag, " ack_latency"}, lat, exp_lat);
        cmp({tag, " set_o"}, set_o, m_set);
        cmp({tag, " error_cnt"}, error_cnt, m_err);
        step();
        cmp({tag, " ack_width"}, ack, 0);
    endtask

    task automatic model_cmd(input string c, input int idx, input int v, input int n,
                             output int lat);
        lat = 0;
        if (c == "SET") begin
            if (idx >= 0 && idx < 16) m_set[idx] = v[0];
            else                      m_err++;
        end else if (c == "CHECK") begin
            if (idx >= 0 && idx < 16) begin
                if (check_i[idx] !== v[0]) m_err++;
            end else begin
                m_err++;
            end
        end else if (c == "WAIT_CYCLES") begin
            lat = n;
        end else if (c == "WTR" || c == "WTF") begin
            m_err++;
            if (idx >= 0 && idx < 16) lat = n;
        end else if (c != "") begin
            m_err++;
        end
    endtask

    task automatic release_and_count(input string tag);
        int acks;
        int first;
        acks  = 0;
        first = -1;
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (ack) begin
                acks++;
                if (first < 0) first = i;
            end
        end
        cmp({tag, " init_ack_count"}, acks, 1);
        cmp({tag, " init_ack_cycle"}, first, 1);
    endtask

    vec_t vt [14];

    initial begin
        int lat;
        string cmds [7];

        vt[0]  = '{"SET",         "3",  "1", 16'h0000, 0,  16'h0008, 0};
        vt[1]  = '{"CHECK",       "3",  "1", 16'h0008, 0,  16'h0008, 0};
        vt[2]  = '{"WAIT_CYCLES", "10", "",  16'h0000, 10, 16'h0008, 0};
        vt[3]  = '{"WAIT_CYCLES", "0",  "",  16'h0000, 0,  16'h0008, 0};
        vt[4]  = '{"FOO",         "1",  "2", 16'h0000, 0,  16'h0008, 1};
        vt[5]  = '{"SET",         "40", "1", 16'h0000, 0,  16'h0008, 2};
        vt[6]  = '{"",            "",   "",  16'h0000, 0,  16'h0008, 2};
        vt[7]  = '{"SET",         "15", "1", 16'h0000, 0,  16'h8008, 2};
        vt[8]  = '{"SET",         "3",  "0", 16'h0000, 0,  16'h8000, 2};
        vt[9]  = '{"CHECK",       "15", "0", 16'h8000, 0,  16'h8000, 3};
        vt[10] = '{"WTF",         "2",  "5", 16'h0000, 5,  16'h8000, 4};
        vt[11] = '{"WAIT_CYCLES", "1",  "",  16'h0000, 1,  16'h8000, 4};
        vt[12] = '{"CHECK",       "16", "0", 16'h0000, 0,  16'h8000, 5};
        vt[13] = '{"SET",         "-1", "1", 16'h0000, 0,  16'h8000, 6};

        cmds = '{"SET", "CHECK", "WAIT_CYCLES", "WTR", "WTF", "", "BOGUS"};
        for (int i = 0; i < 5; i++) args[i] = "";

        // Reset state and the single start-up ack.
        repeat (3) step();
        cmp("reset ack", ack, 0);
        cmp("reset set_o", set_o, 0);
        cmp("reset error_cnt", error_cnt, 0);
        cmp("reset test_done", test_done, 0);
        release_and_count("startup");

        for (int i = 0; i < 14; i++) begin
            check_i = vt[i].chk;
            wait_i  = '0;
            m_set   = vt[i].set;
            m_err   = vt[i].err;
            expect_cmd($sformatf("vec%0d", i), vt[i].c, vt[i].a1, vt[i].a2, vt[i].lat);
        end

        // WTR with the pin rising on edge 20 of a 50-cycle window.
        wait_i = '0;
        step();
        present("WTR", "2", "50");
        lat = 0;
        while (!ack && lat < 200) begin
            if (lat == 19) wait_i[2] = 1'b1;
            step();
            lat++;
        end
        cmp("wtr_edge ack_latency", lat, 20);
        cmp("wtr_edge error_cnt", error_cnt, m_err);
        step();
        wait_i = '0;
        step();

        // Edge coinciding with timeout expiry counts as success.
        present("WTR", "2", "5");
        lat = 0;
        while (!ack && lat < 200) begin
            if (lat == 4) wait_i[2] = 1'b1;
            step();
            lat++;
        end
        cmp("wtr_tie ack_latency", lat, 5);
        cmp("wtr_tie error_cnt", error_cnt, m_err);
        step();
        wait_i = '0;
        step();

        // Strobe during WAIT_CYCLES is a protocol violation but does not disturb timing.
        present("WAIT_CYCLES", "5", "");
        lat = 0;
        while (!ack && lat < 200) begin
            args_valid = (lat == 2);
            step();
            lat++;
        end
        args_valid = 1'b0;
        m_err++;
        cmp("proto ack_latency", lat, 5);
        cmp("proto error_cnt", error_cnt, m_err);
        step();

        // Randomized lines against the model.
        for (int i = 0; i < 120; i++) begin
            int    k;
            int    idx;
            int    v;
            int    n;
            int    exp_lat;
            string a1;
            string a2;
            k   = $urandom_range(0, 6);
            idx = $urandom_range(0, 19);
            v   = $urandom_range(0, 1);
            n   = (k == 3 || k == 4) ? $urandom_range(1, 5) : $urandom_range(0, 6);
            check_i = 16'($urandom);
            wait_i  = 16'($urandom);
            step();
            if (k == 2) begin
                a1 = $sformatf("%0d", n);
                a2 = "";
            end else if (k == 3 || k == 4) begin
                a1 = $sformatf("%0d", idx);
                a2 = $sformatf("%0d", n);
            end else begin
                a1 = $sformatf("%0d", idx);
                a2 = $sformatf("%0d", v);
            end
            model_cmd(cmds[k], idx, v, n, exp_lat);
            expect_cmd($sformatf("rand%0d %s %s %s", i, cmds[k], a1, a2),
                       cmds[k], a1, a2, exp_lat);
        end

        // Reset while a WTR with no timeout is pending.
        wait_i = '0;
        step();
        present("WTR", "2", "0");
        repeat (3) step();
        cmp("midrst pending ack", ack, 0);
        rst_n = 1'b0;
        step();
        cmp("midrst ack", ack, 0);
        cmp("midrst set_o", set_o, 0);
        cmp("midrst error_cnt", error_cnt, 0);
        wait_i[2] = 1'b1;
        step();
        m_set = '0;
        m_err = 0;
        release_and_count("midrst");
        wait_i = '0;

        // Failed CHECK, then END_TEST: sticky done, no more acks.
        check_i = '0;
        m_err   = 1;
        expect_cmd("endchk", "CHECK", "0", "1", 0);
        expect_cmd("end", "END_TEST", "", "", 0);
        cmp("end test_done", test_done, 1);
        begin
            int late_acks;
            late_acks = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (ack) late_acks++;
            end
            cmp("end no_more_ack", late_acks, 0);
        end
        cmp("end error_cnt_final", error_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
